event_irq_arbiter: RTL and testbench
====================================

// Module: event_irq_arbiter
// PURPOSE
//  Collects single-cycle o_Event pulses from NUM_CH event_detector instances,
//  latches each as a pending request with a saturating occurrence count, and
//  schedules them round-robin onto one valid/ready output toward the interrupt/CPU side.
//  Sits directly downstream of the event detector bank. All inputs are synchronous to clk.
// PARAMETERS
//  NUM_CH   4  number of event channels (2..16)
//  COUNT_W  4  width of per-channel occurrence counter (saturating)
//  CH_ID_W  $clog2(NUM_CH)  localparam, width of channel index
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  reset       in   1        synchronous, active-high reset
//  i_Event     in   NUM_CH   event pulses, one bit per channel; each high cycle = 1 event
//  i_Enable    in   NUM_CH   per-channel enable; 0 blocks capture and arbitration
//  i_Ovf_Clr   in   NUM_CH   per-channel clear of sticky overflow flag
//  i_Ready     in   1        consumer accepts current grant when high with o_Valid
//  o_Valid     out  1        grant record valid
//  o_Chan_Id   out  CH_ID_W  granted channel index
//  o_Count     out  COUNT_W  events accumulated on granted channel since its last grant
//  o_Pending   out  NUM_CH   live pending bits (debug/status)
//  o_Overflow  out  NUM_CH   sticky: event lost because counter already saturated
// BEHAVIOUR
//  Reset: o_Valid=0, o_Chan_Id=0, o_Count=0, pending=0, counts=0, o_Overflow=0,
//   last_grant=NUM_CH-1 (channel 0 highest priority after reset). Reset mid-offer
//   drops o_Valid at the next edge; the outstanding grant is discarded.
//  Capture (per ch i, each cycle): if i_Event[i]&i_Enable[i]: pending[i]<=1,
//   count[i]<=count[i]+1 saturating at 2^COUNT_W-1; if already saturated,
//   o_Overflow[i]<=1. Overflow set beats i_Ovf_Clr[i] in the same cycle.
//  Eligibility: req[i] = pending[i] & i_Enable[i]. Disabled channels keep
//   pending/count but are skipped by the arbiter until re-enabled.
//  FSM, two states:
//   IDLE : o_Valid=0. If |req: select winner, go OFFER. Else stay.
//   OFFER: o_Valid=1, o_Chan_Id/o_Count held stable until handshake.
//          On o_Valid&i_Ready: if |req (excluding the just-cleared
//          winner's old pending) select next winner, stay OFFER (back-to-back,
//          1 grant/cycle); else go IDLE. No handshake: hold, no reselection.
//  Selection: first req[] at or after (last_grant+1) mod NUM_CH, wrapping.
//   On selection: o_Chan_Id<=winner, o_Count<=count[winner], last_grant<=winner,
//   pending[winner]<=0, count[winner]<=0. An event on the winner in the same
//   cycle is not lost: pending[winner]<=1, count[winner]<=1.
//  Latency: event at edge t -> pending at t+1 -> o_Valid at t+2 (from IDLE).
//  o_Count never 0 when o_Valid=1. o_Pending reflects pending register directly.
//  Disabling a channel while it is granted does not revoke the offered grant.
// TESTING
//  1 Single event: i_Event=4'b0100 one cycle -> o_Valid 2 cycles later,
//    o_Chan_Id=2, o_Count=1; i_Ready=1 -> o_Valid=0 next cycle, o_Pending=0.
//  2 Round-robin: after reset pulse i_Event=4'b1111, i_Ready=1 constant ->
//    grants ch0,1,2,3 on 4 consecutive cycles, each o_Count=1, then IDLE.
//  3 Saturation: i_Ready=0, ch1 pulses 17 times (COUNT_W=4) -> o_Count=15,
//    o_Overflow[1]=1; i_Ovf_Clr[1]=1 -> o_Overflow[1]=0 next cycle.
//  4 Event during grant: ch0 offered, i_Ready and i_Event[0] same cycle ->
//    grant accepted, pending[0]=1, later grant ch0 with o_Count=1.
//  5 Enable mask: i_Enable=4'b1101, events on ch1 and ch3 -> only ch3 granted;
//    o_Pending[1]=0; re-enable ch1 with new event -> ch1 granted o_Count=1.
//  6 Reset mid-offer: o_Valid=1, assert reset one cycle -> o_Valid=0,
//    o_Pending=0, o_Overflow=0; next event on ch3 granted with o_Count=1.

Source files
------------

// File: rtl/event_irq_arbiter_if.sv
// Grant channel from the event IRQ arbiter to the interrupt/CPU side.
// The arbiter drives the grant record and the consumer returns i_Ready.
interface event_irq_arbiter_if #(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 4
);
  localparam int CH_ID_W = $clog2(NUM_CH);

  logic               o_Valid;
  logic [CH_ID_W-1:0] o_Chan_Id;
  logic [COUNT_W-1:0] o_Count;
  logic               i_Ready;

  modport master (output o_Valid, output o_Chan_Id, output o_Count, input i_Ready);
  modport slave  (input o_Valid, input o_Chan_Id, input o_Count, output i_Ready);
endinterface

// File: rtl/event_irq_arbiter.sv
// Latches event pulses as pending requests with saturating counts and
// grants them round-robin, one record per cycle, over a valid/ready channel.
module event_irq_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    i_Event,
  input  logic [NUM_CH-1:0]    i_Enable,
  input  logic [NUM_CH-1:0]    i_Ovf_Clr,
  output logic [NUM_CH-1:0]    o_Pending,
  output logic [NUM_CH-1:0]    o_Overflow,
  event_irq_arbiter_if.master  grant_if
);
  localparam int CH_ID_W = $clog2(NUM_CH);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  ovf_q, ovf_d;
  logic [COUNT_W-1:0] count_q [NUM_CH];
  logic [COUNT_W-1:0] count_d [NUM_CH];
  logic [CH_ID_W-1:0] last_q, last_d;
  logic [CH_ID_W-1:0] chan_q, chan_d;
  logic [COUNT_W-1:0] ocnt_q, ocnt_d;
  logic [NUM_CH-1:0]  cap, req;
  logic [CH_ID_W-1:0] win;
  logic               sel;

  assign cap = i_Event & i_Enable;
  assign req = pending_q & i_Enable;

  // Descending scan so the nearest requester after last_q is written last and wins.
  always_comb begin
    logic [CH_ID_W-1:0] idx;
    idx = '0;
    win = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = CH_ID_W'((int'(last_q) + k) % NUM_CH);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel     = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (grant_if.i_Ready) begin
          if (|req) sel = 1'b1;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    last_d = sel ? win : last_q;
    chan_d = sel ? win : chan_q;
    ocnt_d = sel ? count_q[win] : ocnt_q;
  end

  // A same-cycle event on the winner restarts its count at 1 instead of being lost.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic hit;
    logic sat;
    assign hit = sel && (win == CH_ID_W'(gi));
    assign sat = (count_q[gi] == CNT_MAX);
    assign pending_d[gi] = hit ? cap[gi] : (pending_q[gi] | cap[gi]);
    assign count_d[gi]   = hit ? COUNT_W'(cap[gi]) :
                           (cap[gi] && !sat) ? count_q[gi] + 1'b1 : count_q[gi];
    assign ovf_d[gi]     = (!hit && cap[gi] && sat) ? 1'b1 :
                           i_Ovf_Clr[gi] ? 1'b0 : ovf_q[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ovf_q     <= '0;
      last_q    <= CH_ID_W'(NUM_CH - 1);
      chan_q    <= '0;
      ocnt_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) count_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      last_q    <= last_d;
      chan_q    <= chan_d;
      ocnt_q    <= ocnt_d;
      for (int i = 0; i < NUM_CH; i++) count_q[i] <= count_d[i];
    end
  end

  assign grant_if.o_Valid   = (state_q == OFFER);
  assign grant_if.o_Chan_Id = chan_q;
  assign grant_if.o_Count   = ocnt_q;
  assign o_Pending          = pending_q;
  assign o_Overflow         = ovf_q;
endmodule

// File: tb/tb_event_irq_arbiter.sv
// Directed bench for event_irq_arbiter: expected grants are queued when events
// are driven and compared against each accepted grant record.
module tb_event_irq_arbiter;
  localparam int NUM_CH  = 4;
  localparam int COUNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ev, en, clr;
  logic [NUM_CH-1:0] pend, ovf;

  int vectors     = 0;
  int miscompares = 0;
  int exp_chan_q[$];
  int exp_cnt_q[$];

  event_irq_arbiter_if #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W)) bus ();

  event_irq_arbiter #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_Event    (ev),
    .i_Enable   (en),
    .i_Ovf_Clr  (clr),
    .o_Pending  (pend),
    .o_Overflow (ovf),
    .grant_if   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int ch, input int cnt);
    exp_chan_q.push_back(ch);
    exp_cnt_q.push_back(cnt);
  endtask

  // Inputs are stable here (#1 after an edge); a handshake at the coming edge pops the scoreboard.
  task automatic cycle();
    int ech, ecnt;
    if (bus.o_Valid === 1'b1 && bus.i_Ready === 1'b1) begin
      $display("grant ch=%0d count=%0d", bus.o_Chan_Id, bus.o_Count);
      if (exp_chan_q.size() == 0) begin
        chk("unexpected_grant", 32'(bus.o_Chan_Id), 32'hFFFF_FFFF);
      end else begin
        ech  = exp_chan_q.pop_front();
        ecnt = exp_cnt_q.pop_front();
        chk("grant_chan", 32'(bus.o_Chan_Id), 32'(ech));
        chk("grant_count", 32'(bus.o_Count), 32'(ecnt));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.o_Valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk("valid_timeout", 32'(bus.o_Valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1; ev = '0; en = 4'b1111; clr = '0; bus.i_Ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_valid", 32'(bus.o_Valid), 32'd0);
    chk("rst_chan", 32'(bus.o_Chan_Id), 32'd0);
    chk("rst_count", 32'(bus.o_Count), 32'd0);
    chk("rst_pending", 32'(pend), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);

    // Single event on ch2
    ev = 4'b0100; expect_grant(2, 1); cycle(); ev = '0;
    chk("t1_valid_lat1", 32'(bus.o_Valid), 32'd0);
    chk("t1_pending", 32'(pend), 32'b0100);
    cycle();
    chk("t1_valid_lat2", 32'(bus.o_Valid), 32'd1);
    chk("t1_chan", 32'(bus.o_Chan_Id), 32'd2);
    chk("t1_count", 32'(bus.o_Count), 32'd1);
    bus.i_Ready = 1'b1; cycle(); bus.i_Ready = 1'b0;
    chk("t1_valid_after", 32'(bus.o_Valid), 32'd0);
    chk("t1_pending_after", 32'(pend), 32'd0);

    // Round-robin after reset
    reset = 1'b1; cycle(); reset = 1'b0;
    ev = 4'b1111; bus.i_Ready = 1'b1;
    for (int k = 0; k < 4; k++) expect_grant(k, 1);
    cycle(); ev = '0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", 32'(bus.o_Valid), 32'd1);
      chk("t2_chan", 32'(bus.o_Chan_Id), 32'(k));
      cycle();
    end
    chk("t2_idle", 32'(bus.o_Valid), 32'd0);
    bus.i_Ready = 1'b0;

    // Saturation on ch1 while ch0 is held on offer
    ev = 4'b0001; expect_grant(0, 1); cycle(); ev = '0; cycle();
    chk("t3_offer_ch0", 32'(bus.o_Chan_Id), 32'd0);
    for (int k = 0; k < 17; k++) begin
      ev = 4'b0010; cycle();
    end
    ev = '0;
    chk("t3_overflow", 32'(ovf), 32'b0010);
    chk("t3_pending", 32'(pend), 32'b0011 & 32'b0010);
    ev = 4'b0010; clr = 4'b0010; cycle(); ev = '0;
    chk("t3_set_beats_clr", 32'(ovf), 32'b0010);
    cycle(); clr = '0;
    chk("t3_ovf_cleared", 32'(ovf), 32'd0);
    expect_grant(1, 15);
    bus.i_Ready = 1'b1; cycle();
    chk("t3_b2b_chan", 32'(bus.o_Chan_Id), 32'd1);
    chk("t3_b2b_count", 32'(bus.o_Count), 32'd15);
    cycle(); bus.i_Ready = 1'b0;
    chk("t3_idle", 32'(bus.o_Valid), 32'd0);

    // Event on the offered channel in the handshake cycle
    ev = 4'b0001; expect_grant(0, 1); cycle(); ev = '0; cycle();
    bus.i_Ready = 1'b1; ev = 4'b0001; expect_grant(0, 1); cycle(); ev = '0;
    chk("t4_idle", 32'(bus.o_Valid), 32'd0);
    chk("t4_pending", 32'(pend), 32'b0001);
    cycle();
    chk("t4_regrant", 32'(bus.o_Valid), 32'd1);
    cycle(); bus.i_Ready = 1'b0;

    // Enable mask
    en = 4'b1101; ev = 4'b1010; expect_grant(3, 1); cycle(); ev = '0;
    chk("t5_pending", 32'(pend), 32'b1000);
    bus.i_Ready = 1'b1; cycle();
    chk("t5_chan", 32'(bus.o_Chan_Id), 32'd3);
    cycle();
    chk("t5_idle", 32'(bus.o_Valid), 32'd0);
    chk("t5_pend1", 32'(pend[1]), 32'd0);
    en = 4'b1111; ev = 4'b0010; expect_grant(1, 1); cycle(); ev = '0;
    wait_valid(10);
    cycle(); bus.i_Ready = 1'b0;

    // Reset while a grant is on offer
    ev = 4'b0100; cycle(); ev = '0; cycle();
    chk("t6_offer", 32'(bus.o_Valid), 32'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("t6_valid", 32'(bus.o_Valid), 32'd0);
    chk("t6_pending", 32'(pend), 32'd0);
    chk("t6_overflow", 32'(ovf), 32'd0);
    ev = 4'b1000; expect_grant(3, 1); cycle(); ev = '0;
    bus.i_Ready = 1'b1;
    wait_valid(10);
    cycle(); bus.i_Ready = 1'b0;
    cycle();

    chk("sb_empty", 32'(exp_chan_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
